// File: rtl/pmu_c910_pkg.sv
// Shared definitions for the PMU event synchronizer: fast-side FSM encoding
// and the default synchronizer depth.
`timescale 1ns/1ps
package pmu_c910_pkg;

  localparam int SYNC_STG_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } evt_st_e;

endpackage

// File: rtl/sync_stg_c910.sv
// Multi-flop synchronizer chain with asynchronous active-low reset.
// All clock-crossing synchronization in the PMU event path goes through here.
`timescale 1ns/1ps
module sync_stg_c910
  import pmu_c910_pkg::*;
#(
  parameter int STG = SYNC_STG_DEF
) (
  input  logic clk,
  input  logic rst_b,
  input  logic d,
  output logic q
);

  logic [STG-1:0] chain_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STG-2:0], d};
    end
  end

  assign q = chain_q[STG-1];

endmodule

// File: rtl/pmu_evt_sync_c910.sv
// Per-channel fast->slow event transfer using a four-phase req/ack handshake,
// one-deep pending buffer and a saturating merge counter per channel.
`timescale 1ns/1ps
module pmu_evt_sync_c910
  import pmu_c910_pkg::*;
#(
  parameter int CH       = 4,
  parameter int SYNC_STG = SYNC_STG_DEF,
  parameter int CNT_W    = 4
) (
  input  logic                fast_clk,
  input  logic                pad_cpu_rst_b,
  input  logic                slow_clk,
  input  logic [CH-1:0]       in,
  input  logic                cnt_clr,
  output logic [CH-1:0]       out,
  output logic [CH-1:0]       busy,
  output logic [CH*CNT_W-1:0] merge_cnt
);

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    evt_st_e            state_q;
    logic               req_q;
    logic               pend_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               req_s;
    logic               ack_q;
    logic               ack_f;

    sync_stg_c910 #(.STG(SYNC_STG)) u_req_sync (
      .clk   (slow_clk),
      .rst_b (pad_cpu_rst_b),
      .d     (req_q),
      .q     (req_s)
    );

    always_ff @(posedge slow_clk or negedge pad_cpu_rst_b) begin
      if (!pad_cpu_rst_b) begin
        ack_q <= 1'b0;
      end else begin
        ack_q <= req_s;
      end
    end

    sync_stg_c910 #(.STG(SYNC_STG)) u_ack_sync (
      .clk   (fast_clk),
      .rst_b (pad_cpu_rst_b),
      .d     (ack_q),
      .q     (ack_f)
    );

    assign out[gi] = req_s & ~ack_q;

    always_ff @(posedge fast_clk or negedge pad_cpu_rst_b) begin
      if (!pad_cpu_rst_b) begin
        state_q <= ST_IDLE;
        req_q   <= 1'b0;
        pend_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_REQ: begin
            if (in[gi]) pend_q <= 1'b1;
            if (ack_f) begin
              req_q   <= 1'b0;
              state_q <= ST_REL;
            end
          end
          ST_REL: begin
            if (in[gi]) pend_q <= 1'b1;
            if (!ack_f) state_q <= ST_IDLE;
          end
          // Encoding 3 is unreachable and behaves as IDLE.
          default: begin
            state_q <= ST_IDLE;
            if (in[gi] || pend_q) begin
              req_q   <= 1'b1;
              pend_q  <= 1'b0;
              state_q <= ST_REQ;
            end
          end
        endcase
      end
    end

    // Any event seen while pend is already set is merged, whichever the state.
    always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
        cnt_d = '0;
      end else if (in[gi] && pend_q && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge fast_clk or negedge pad_cpu_rst_b) begin
      if (!pad_cpu_rst_b) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign busy[gi] = (state_q != ST_IDLE) | pend_q;
    assign merge_cnt[gi*CNT_W +: CNT_W] = cnt_q;
  end

endmodule
